// File: rtl/bram_fifo_pkg.sv
// bram_fifo_pkg: shared constants for the block-RAM stream FIFO controller.
//   BRAM_DEPTH/BRAM_AW/BRAM_DW : geometry of the 512x32 dual-port RAM
//   QDEPTH/QCNT_W              : size of the output prefetch queue and its counter width
//   CNT_W                      : width of the total occupancy count (RAM + in-flight + queue)
package bram_fifo_pkg;

    localparam int unsigned BRAM_DEPTH = 512;
    localparam int unsigned BRAM_AW    = 9;
    localparam int unsigned BRAM_DW    = 32;

    localparam int unsigned QDEPTH     = 2;
    localparam int unsigned QCNT_W     = 2;

    localparam int unsigned CNT_W      = BRAM_AW + 2;

endpackage

// File: rtl/bram_fifo_skid.sv
// bram_fifo_skid: 2-entry output queue that absorbs the RAM's registered read.
// Ports:
//   CLK, reset      : clock, asynchronous active-high reset
//   append, data    : capture a word from the RAM read port into the tail
//   pop             : downstream consumed the head word
//   qcnt            : entries held (0..2)
//   head, out_valid : head word and its valid flag
module bram_fifo_skid
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DW = BRAM_DW
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              append,
    input  logic [DW-1:0]     data,
    input  logic              pop,
    output logic [QCNT_W-1:0] qcnt,
    output logic [DW-1:0]     head,
    output logic              out_valid
);

    logic [DW-1:0]     head_q, head_d;
    logic [DW-1:0]     tail_q, tail_d;
    logic [QCNT_W-1:0] qcnt_q, qcnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        qcnt_d = qcnt_q;
        case ({append, pop})
            2'b10: begin
                if (qcnt_q == 2'd0) begin
                    head_d = data;
                end else begin
                    tail_d = data;
                end
                qcnt_d = qcnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                qcnt_d = qcnt_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: with one entry the new word replaces the
                // head directly, with two it moves in behind the promoted tail.
                if (qcnt_q == 2'd1) begin
                    head_d = data;
                end else begin
                    head_d = tail_q;
                    tail_d = data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            qcnt_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            qcnt_q <= qcnt_d;
        end
    end

    assign qcnt      = qcnt_q;
    assign head      = head_q;
    assign out_valid = (qcnt_q != 2'd0);

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: stream FIFO controller in front of an external dual-port
// block RAM. Port A writes accepted input words, port B reads them back into a
// 2-entry prefetch queue so the 1-cycle registered read still sustains one
// word per cycle at the ready/valid output.
// Ports:
//   CLK, reset                      : clock, asynchronous active-high reset
//   in_valid, in_data, in_ready     : upstream ready/valid
//   out_valid, out_data, out_ready  : downstream ready/valid
//   count                           : words held (RAM + in-flight read + queue)
//   ram_ena/wea/addra/dia           : RAM port A (write)
//   ram_enb/web/addrb, ram_dob      : RAM port B (read), ram_web tied low
// Optional: define BRAM_FIFO_ALMOST_FULL_EN to add the registered almost_full
// output (next-cycle count >= AF_LEVEL).
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = BRAM_DEPTH,
    parameter int unsigned AW       = BRAM_AW,
    parameter int unsigned DW       = BRAM_DW,
    parameter int unsigned AF_LEVEL = 480
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW+1:0] count,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dia,
    output logic          ram_enb,
    output logic          ram_web,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_dob
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    ,
    output logic          almost_full
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       ram_cnt_q, ram_cnt_d;
    logic              inflight_q, inflight_d;

    logic              push, pop, issue;
    logic [2:0]        q_occ;
    logic [QCNT_W-1:0] qcnt;
    logic              q_valid;
    logic [DW-1:0]     q_head;

    always_comb begin
        in_ready = !reset && (ram_cnt_q != DEPTH_C);
        push     = in_valid && in_ready;
        pop      = q_valid && out_ready;
        // Queue slots already spoken for next cycle; pop implies qcnt >= 1,
        // so the subtraction never underflows.
        q_occ    = 3'(qcnt) + 3'(inflight_q) - 3'(pop);
        issue    = !reset && (ram_cnt_q != '0) && (q_occ < 3'(QDEPTH));

        wr_ptr_d   = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        inflight_d = issue;

        ram_cnt_d = ram_cnt_q;
        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    bram_fifo_skid #(
        .DW (DW)
    ) u_skid (
        .CLK       (CLK),
        .reset     (reset),
        .append    (inflight_q),
        .data      (ram_dob),
        .pop       (pop),
        .qcnt      (qcnt),
        .head      (q_head),
        .out_valid (q_valid)
    );

    assign out_valid = q_valid;
    assign out_data  = q_head;
    assign count     = (AW+2)'(ram_cnt_q) + (AW+2)'(inflight_q) + (AW+2)'(qcnt);

    assign ram_ena   = push;
    assign ram_wea   = push;
    assign ram_addra = wr_ptr_q;
    assign ram_dia   = in_data;
    assign ram_enb   = issue;
    assign ram_web   = 1'b0;
    assign ram_addrb = rd_ptr_q;

`ifdef BRAM_FIFO_ALMOST_FULL_EN
    logic          almost_full_q, almost_full_d;
    logic [AW+1:0] count_next;

    always_comb begin
        // Next-cycle occupancy: queue gains the in-flight word, loses a pop.
        count_next    = (AW+2)'(ram_cnt_d) + (AW+2)'(inflight_d)
                      + (AW+2)'(qcnt) + (AW+2)'(inflight_q) - (AW+2)'(pop);
        almost_full_d = (32'(count_next) >= AF_LEVEL);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
        end
    end

    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: scoreboard bench for bram_fifo_ctrl with a behavioural
// dual-port RAM. Expected words are queued on acceptance and popped by an
// independent monitor whenever the DUT hands a word downstream; occupancy is
// modelled as words accepted minus words delivered.
module tb_bram_fifo_ctrl;
    import bram_fifo_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          CLK = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [AW+1:0] count;
    logic          ram_ena, ram_wea, ram_enb, ram_web;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dia;
    logic [DW-1:0] ram_dob = '0;
`ifdef BRAM_FIFO_ALMOST_FULL_EN
    logic          almost_full;
`endif

    always #5 CLK = ~CLK;

    bram_fifo_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .DW       (DW),
        .AF_LEVEL (480)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dia   (ram_dia),
        .ram_enb   (ram_enb),
        .ram_web   (ram_web),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob)
`ifdef BRAM_FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

    // Behavioural 512x32 dual-port RAM; read data registered, held while disabled.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end
    always @(posedge CLK) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] expq [$];
    int            model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, output logic acc);
        @(negedge CLK);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (acc) expq.push_back(d);
    endtask

    task automatic drain(input int budget);
        logic acc;
        int   n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            cyc(1'b0, '0, 1'b1, acc);
            n++;
        end
        cyc(1'b0, '0, 1'b1, acc);
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    // Monitor: occupancy, handshake rules and in-order data delivery.
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge CLK);
            #2;
            if (reset) begin
                chk("reset_count", 32'(count), 32'd0);
                chk("reset_out_valid", 32'(out_valid), 32'd0);
                chk("reset_in_ready", 32'(in_ready), 32'd0);
                chk("reset_enables", {30'd0, ram_ena, ram_enb}, 32'd0);
                model_cnt = 0;
            end else begin
                chk("count", 32'(count), 32'(model_cnt));
                chk("ram_web", 32'(ram_web), 32'd0);
                chk("ram_ena", 32'(ram_ena), 32'(in_valid && in_ready));
                if (model_cnt < DEPTH) chk("in_ready_notfull", 32'(in_ready), 32'd1);
                if (model_cnt == DEPTH + 2) chk("in_ready_full", 32'(in_ready), 32'd0);
                if (model_cnt == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
                if (ram_ena && ram_enb) chk("addr_collision", 32'(ram_addra == ram_addrb), 32'd0);
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
                    end else begin
                        exp_w = expq.pop_front();
                        chk("out_data", out_data, exp_w);
                    end
                end
                model_cnt = model_cnt + int'(in_valid && in_ready) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        logic acc;
        int   n;
        int   cycles;

        reset = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b0;

        // Single word: accepted in cycle N, visible at N+3.
        cyc(1'b1, 32'hDEADBEEF, 1'b1, acc);
        chk("single_accept", 32'(acc), 32'd1);
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_n1_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_n2_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, '0, 1'b1, acc);
        chk("single_n3_valid", 32'(out_valid), 32'd1);
        chk("single_n3_data", out_data, 32'hDEADBEEF);
        drain(10);

        // Streaming 1000 words; pointers wrap past 512.
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, 32'(i), 1'b1, acc);
            chk("stream_in_ready", 32'(acc), 32'd1);
        end
        drain(20);

        // Fill with the output stalled.
        n = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1'b1, 32'(n), 1'b0, acc);
            if (!acc) break;
            n++;
        end
        chk("fill_accepted", 32'(n), 32'(DEPTH + 2));

        // Full with a simultaneous read issue: in_ready stays low, rises next cycle.
        cyc(1'b1, 32'(n), 1'b1, acc);
        chk("full_issue_in_ready", 32'(acc), 32'd0);
        cyc(1'b1, 32'(n), 1'b0, acc);
        chk("after_issue_in_ready", 32'(acc), 32'd1);
        drain(700);

        // Random stalls.
        n = 0;
        cycles = 0;
        while (n < 10000 && cycles < 60000) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), acc);
            if (acc) n++;
            cycles++;
        end
        chk("random_accepted", 32'(n), 32'd10000);
        drain(700);

        // Reset with 100 words held and a read in flight.
        for (int i = 0; i < 101; i++) cyc(1'b1, 32'(i + 32'h100), 1'b0, acc);
        repeat (4) cyc(1'b0, '0, 1'b0, acc);
        cyc(1'b0, '0, 1'b1, acc);
        @(negedge CLK);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expq.delete();
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_out_data", out_data, 32'd0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        cyc(1'b1, 32'h5, 1'b1, acc);
        chk("post_reset_accept", 32'(acc), 32'd1);
        cyc(1'b0, '0, 1'b1, acc);
        cyc(1'b0, '0, 1'b1, acc);
        cyc(1'b0, '0, 1'b1, acc);
        chk("post_reset_first_valid", 32'(out_valid), 32'd1);
        chk("post_reset_first_data", out_data, 32'h5);
        drain(10);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
